// File: rtl/rmw_seq.sv
// Read-modify-write sequencer in front of the combinational 6502 ALU.
// Fetches one operand, evaluates it in the ALU, and performs the dummy-then-final double write for shift/inc ops.
module rmw_seq #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [AW-1:0] ADDR,
    input  logic [3:0]    OP,
    input  logic [DW-1:0] OPB,
    input  logic [DW-1:0] FLAG_IN,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_RE,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_WDATA,
    output logic [DW-1:0] ALU_A,
    output logic [DW-1:0] ALU_B,
    output logic [3:0]    ALU_CTRL,
    output logic [DW-1:0] ALU_FLAG,
    input  logic [DW-1:0] ALU_OUT,
    input  logic [DW-1:0] ALU_FLAG_OUT,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] FLAG_OUT,
    output logic          FLAG_WE,
    output logic [2:0]    DBG_STATE
);

    localparam logic [3:0] C_ALU_CTRL_ASL = 4'd7;
    localparam logic [3:0] C_ALU_CTRL_LSR = 4'd8;
    localparam logic [3:0] C_ALU_CTRL_ROL = 4'd9;
    localparam logic [3:0] C_ALU_CTRL_ROR = 4'd10;
    localparam logic [3:0] C_ALU_CTRL_INC = 4'd11;
    localparam logic [3:0] C_ALU_CTRL_DEC = 4'd12;

    // Handshake: START is a request pulse honoured only while BUSY=0 (IDLE) and never queued;
    // DONE and FLAG_WE pulse together for one cycle, and FLAG_OUT then holds until the next completion.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_EVAL = 3'd3,
        S_DWR  = 3'd4,
        S_FWR  = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    op_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] flag_in_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] flag_q;
    logic [DW-1:0] flag_out_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_re_q;
    logic          mem_we_q;
    logic          done_q;
    logic          flag_we_q;

    function automatic logic is_rmw(input logic [3:0] op);
        case (op)
            C_ALU_CTRL_ASL, C_ALU_CTRL_LSR, C_ALU_CTRL_ROL,
            C_ALU_CTRL_ROR, C_ALU_CTRL_INC, C_ALU_CTRL_DEC: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Strobes are registered and default low each cycle, so reset drops them without waiting for a clock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= '0;
            opb_q       <= '0;
            flag_in_q   <= '0;
            data_q      <= '0;
            flag_q      <= '0;
            flag_out_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            flag_we_q   <= 1'b0;
        end else begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            done_q      <= 1'b0;
            flag_we_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        addr_q     <= ADDR;
                        op_q       <= OP;
                        opb_q      <= OPB;
                        flag_in_q  <= FLAG_IN;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= ADDR;
                        state_q    <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    data_q <= MEM_RDATA;
                    if (is_rmw(op_q)) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= MEM_RDATA;
                        mem_addr_q  <= addr_q;
                        state_q     <= S_DWR;
                    end else begin
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    flag_q     <= ALU_FLAG_OUT;
                    flag_out_q <= ALU_FLAG_OUT;
                    done_q     <= 1'b1;
                    flag_we_q  <= 1'b1;
                    state_q    <= S_FIN;
                end
                S_DWR: begin
                    // ALU has seen data_q for a full cycle; its result becomes the final write.
                    flag_q      <= ALU_FLAG_OUT;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= ALU_OUT;
                    mem_addr_q  <= addr_q;
                    state_q     <= S_FWR;
                end
                S_FWR: begin
                    flag_out_q <= flag_q;
                    done_q     <= 1'b1;
                    flag_we_q  <= 1'b1;
                    state_q    <= S_FIN;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign MEM_ADDR  = mem_addr_q;
    assign MEM_RE    = mem_re_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_WDATA = mem_wdata_q;
    assign ALU_A     = data_q;
    assign ALU_B     = opb_q;
    assign ALU_CTRL  = op_q;
    assign ALU_FLAG  = flag_in_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign FLAG_OUT  = flag_out_q;
    assign FLAG_WE   = flag_we_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_rmw_seq.sv
// Testbench for rmw_seq: behavioural memory and ALU around the sequencer, directed plan cases plus random ops.
module tb_rmw_seq;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_BIT = 4'd6;
    localparam logic [3:0] OP_ASL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;
    localparam logic [3:0] OP_INC = 4'd11;
    localparam logic [3:0] OP_DEC = 4'd12;
    localparam logic [3:0] OP_THA = 4'd13;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [15:0] ADDR;
    logic [3:0]  OP;
    logic [7:0]  OPB;
    logic [7:0]  FLAG_IN;
    logic [15:0] MEM_ADDR;
    logic        MEM_RE;
    logic [7:0]  MEM_RDATA;
    logic        MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_CTRL;
    logic [7:0]  ALU_FLAG;
    logic [7:0]  ALU_OUT;
    logic [7:0]  ALU_FLAG_OUT;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  FLAG_OUT;
    logic        FLAG_WE;
    logic [2:0]  DBG_STATE;

    rmw_seq #(.AW(16), .DW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ADDR(ADDR), .OP(OP), .OPB(OPB),
        .FLAG_IN(FLAG_IN), .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA),
        .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_CTRL(ALU_CTRL), .ALU_FLAG(ALU_FLAG), .ALU_OUT(ALU_OUT),
        .ALU_FLAG_OUT(ALU_FLAG_OUT), .BUSY(BUSY), .DONE(DONE), .FLAG_OUT(FLAG_OUT),
        .FLAG_WE(FLAG_WE), .DBG_STATE(DBG_STATE)
    );

    // Clock / reset-free watchdog
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // 6502-style ALU: N=bit7, V=bit6, Z=bit1, C=bit0; other flag bits pass through. CMP reports borrow in C.
    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] f);
        logic [8:0] s;
        logic [7:0] o;
        logic [7:0] nf;
        logic       nz;
        nf = f;
        o  = a;
        nz = 1'b1;
        s  = '0;
        case (op)
            OP_ADC: begin
                s = {1'b0, a} + {1'b0, b} + {8'h00, f[0]};
                o = s[7:0]; nf[0] = s[8]; nf[6] = (a[7] == b[7]) && (o[7] != a[7]);
            end
            OP_SBC: begin
                s = {1'b0, a} + {1'b0, ~b} + {8'h00, f[0]};
                o = s[7:0]; nf[0] = s[8]; nf[6] = (a[7] != b[7]) && (o[7] != a[7]);
            end
            OP_AND: o = a & b;
            OP_ORA: o = a | b;
            OP_EOR: o = a ^ b;
            OP_CMP: begin o = a - b; nf[0] = (a < b); end
            OP_BIT: begin nz = 1'b0; nf[7] = a[7]; nf[6] = a[6]; nf[1] = ((a & b) == 8'h00); end
            OP_ASL: begin nf[0] = a[7]; o = {a[6:0], 1'b0}; end
            OP_LSR: begin nf[0] = a[0]; o = {1'b0, a[7:1]}; end
            OP_ROL: begin nf[0] = a[7]; o = {a[6:0], f[0]}; end
            OP_ROR: begin nf[0] = a[0]; o = {f[0], a[7:1]}; end
            OP_INC: o = a + 8'd1;
            OP_DEC: o = a - 8'd1;
            OP_THA: o = a;
            default: nz = 1'b0;
        endcase
        if (nz) begin
            nf[7] = o[7];
            nf[1] = (o == 8'h00);
        end
        return {nf, o};
    endfunction

    always_comb {ALU_FLAG_OUT, ALU_OUT} = alu_f(ALU_CTRL, ALU_A, ALU_B, ALU_FLAG);

    // Memory model and bus monitor
    logic [7:0]  mem [0:65535];
    logic [15:0] wr_a_q[$];
    logic [7:0]  wr_d_q[$];
    int          done_log[$];
    logic [7:0]  flag_log[$];
    int          cyc = 0;
    int          rd_cnt = 0;
    int          ovl = 0;
    bit          force_en = 1'b0;
    logic [7:0]  force_val = 8'h00;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (MEM_RE) begin
            MEM_RDATA <= force_en ? force_val : mem[MEM_ADDR];
            rd_cnt    <= rd_cnt + 1;
        end
        if (MEM_WE) begin
            mem[MEM_ADDR] = MEM_WDATA;
            wr_a_q.push_back(MEM_ADDR);
            wr_d_q.push_back(MEM_WDATA);
        end
        if (MEM_RE && MEM_WE) ovl <= ovl + 1;
        if (DONE) begin
            done_log.push_back(cyc);
            flag_log.push_back(FLAG_OUT);
        end
    end

    // Scoreboard
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit is_rmw_op(input logic [3:0] op);
        return op inside {OP_INC, OP_DEC, OP_ASL, OP_LSR, OP_ROL, OP_ROR};
    endfunction

    // Driver: one complete operation, with optional corruption of the inputs after START is taken
    task automatic run_op(input logic [3:0] op, input logic [15:0] addr, input logic [7:0] opb,
                          input logic [7:0] flg, input logic [7:0] mv, input bit scramble,
                          input string tag, output logic [7:0] got_flag);
        logic [15:0] exp;
        int          start_cyc;
        int          done_cyc;
        int          rd0;
        logic        got_we;
        bit          rmw;
        exp      = alu_f(op, mv, opb, flg);
        rmw      = is_rmw_op(op);
        mem[addr] = mv;
        wr_a_q.delete();
        wr_d_q.delete();
        rd0      = rd_cnt;
        got_flag = 8'hxx;
        got_we   = 1'b0;
        @(negedge CLK);
        START = 1'b1; ADDR = addr; OP = op; OPB = opb; FLAG_IN = flg;
        start_cyc = cyc;
        @(negedge CLK);
        START = 1'b0;
        if (scramble) begin
            ADDR = ~addr; OP = 4'($urandom); OPB = ~opb; FLAG_IN = ~flg;
        end
        done_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            if (DONE) begin
                done_cyc = cyc; got_flag = FLAG_OUT; got_we = FLAG_WE;
                break;
            end
            @(negedge CLK);
        end
        check({tag, " latency"}, 32'(done_cyc - start_cyc), rmw ? 32'd5 : 32'd4);
        check({tag, " flag_out"}, 32'(got_flag), 32'(exp[15:8]));
        check({tag, " flag_we"}, 32'(got_we), 32'd1);
        @(negedge CLK);
        check({tag, " busy_after"}, 32'(BUSY), 32'd0);
        check({tag, " flag_hold"}, 32'(FLAG_OUT), 32'(exp[15:8]));
        check({tag, " reads"}, 32'(rd_cnt - rd0), 32'd1);
        check({tag, " writes"}, 32'(wr_d_q.size()), rmw ? 32'd2 : 32'd0);
        if (rmw && wr_d_q.size() == 2) begin
            check({tag, " dummy_data"}, 32'(wr_d_q[0]), 32'(mv));
            check({tag, " final_data"}, 32'(wr_d_q[1]), 32'(exp[7:0]));
            check({tag, " dummy_addr"}, 32'(wr_a_q[0]), 32'(addr));
            check({tag, " final_addr"}, 32'(wr_a_q[1]), 32'(addr));
        end
    endtask

    initial begin
        logic [7:0] f;
        int         rd0;
        // Reset
        RST_N = 1'b0; START = 1'b0; ADDR = '0; OP = '0; OPB = '0; FLAG_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst busy", 32'(BUSY), 32'd0);
        check("rst done", 32'(DONE), 32'd0);
        check("rst flag_we", 32'(FLAG_WE), 32'd0);
        check("rst flag_out", 32'(FLAG_OUT), 32'd0);
        check("rst mem_re", 32'(MEM_RE), 32'd0);
        check("rst mem_we", 32'(MEM_WE), 32'd0);
        check("rst mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst state", 32'(DBG_STATE), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Directed cases
        run_op(OP_INC, 16'h0200, 8'h00, 8'h20, 8'h7F, 1'b0, "inc", f);
        check("inc flag_const", 32'(f), 32'h0000_00A0);
        run_op(OP_ROL, 16'h0210, 8'h00, 8'h01, 8'h80, 1'b0, "rol", f);
        check("rol flag_const", 32'(f), 32'h0000_0001);
        run_op(OP_CMP, 16'h0220, 8'h10, 8'h00, 8'h10, 1'b0, "cmp", f);
        check("cmp flag_const", 32'(f), 32'h0000_0002);
        run_op(OP_ASL, 16'h1234, 8'h5A, 8'h00, 8'hC1, 1'b1, "asl_scramble", f);
        run_op(OP_ADC, 16'h4321, 8'h7F, 8'h01, 8'h01, 1'b1, "adc_scramble", f);

        // Random operations
        for (int n = 0; n < 24; n++) begin
            run_op(4'($urandom_range(0, 15)), 16'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 1'($urandom_range(0, 1)), "rand", f);
        end

        // START held high: INC on a location that always reads FF
        force_en = 1'b1; force_val = 8'hFF;
        wr_a_q.delete(); wr_d_q.delete(); done_log.delete(); flag_log.delete();
        rd0 = rd_cnt;
        @(negedge CLK);
        START = 1'b1; OP = OP_INC; ADDR = 16'h0300; OPB = 8'h00; FLAG_IN = 8'h00;
        repeat (20) @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        force_en = 1'b0;
        check("b2b ops", 32'(done_log.size()), 32'd4);
        check("b2b reads", 32'(rd_cnt - rd0), 32'd4);
        check("b2b writes", 32'(wr_d_q.size()), 32'd8);
        for (int i = 1; i < done_log.size(); i++)
            check("b2b spacing", 32'(done_log[i] - done_log[i-1]), 32'd6);
        for (int i = 0; i < flag_log.size(); i++)
            check("b2b flag", 32'(flag_log[i]), 32'h02);
        for (int i = 0; i < wr_d_q.size(); i++)
            check("b2b wdata", 32'(wr_d_q[i]), (i % 2 == 0) ? 32'hFF : 32'h00);

        // Reset during the dummy write
        mem[16'h0400] = 8'h3C;
        wr_a_q.delete(); wr_d_q.delete();
        @(negedge CLK);
        START = 1'b1; OP = OP_INC; ADDR = 16'h0400; OPB = 8'h00; FLAG_IN = 8'h00;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 10 && !MEM_WE; i++) @(negedge CLK);
        check("rst_mid reach_dwr", 32'(MEM_WE), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        check("rst_mid we_drop", 32'(MEM_WE), 32'd0);
        check("rst_mid busy_drop", 32'(BUSY), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (8) @(negedge CLK);
        check("rst_mid busy", 32'(BUSY), 32'd0);
        check("rst_mid state", 32'(DBG_STATE), 32'd0);
        check("rst_mid flag_out", 32'(FLAG_OUT), 32'd0);
        check("rst_mid writes", 32'(wr_d_q.size()), 32'd0);
        check("rst_mid mem", 32'(mem[16'h0400]), 32'h3C);

        // A normal op still works after the interrupted one
        run_op(OP_DEC, 16'h0500, 8'h00, 8'h00, 8'h01, 1'b0, "dec_after_rst", f);
        check("dec flag_const", 32'(f), 32'h0000_0002);

        check("re_we_overlap", 32'(ovl), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rmw_seq.md
Name: rmw_seq

Overview:
Read-modify-write sequencer that sits directly upstream of the combinational 6502 ALU. It fetches a memory operand, presents it to the ALU and captures the ALU result and flags. For shift/increment ops it performs the 6502 double write: a dummy write of the original value, then the modified value. For read-only ALU ops (BIT/CMP/AND/ORA/EOR/ADC/SBC/THA) it performs the read and evaluation only, with no writes.

Parameters:
AW, 16, memory address width
DW, 8, data width; only 8 is supported

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  request pulse, sampled only in IDLE
ADDR  input  AW  operand address, latched on accepted START
OP  input  4  ALU control code (C_ALU_CTRL_* from params.vh), latched on START
OPB  input  8  ALU B operand (for read-only ops), latched on START
FLAG_IN  input  8  processor status, latched on START
MEM_ADDR  output  AW  memory address
MEM_RE  output  1  read strobe; MEM_RDATA valid the following cycle
MEM_RDATA  input  8  read data
MEM_WE  output  1  write strobe
MEM_WDATA  output  8  write data
ALU_A  output  8  to ALU A
ALU_B  output  8  to ALU B
ALU_CTRL  output  4  to ALU CTRL
ALU_FLAG  output  8  to ALU FLAG_IN
ALU_OUT  input  8  from ALU OUT
ALU_FLAG_OUT  input  8  from ALU FLAG_OUT
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle completion pulse
FLAG_OUT  output  8  latched result flags
FLAG_WE  output  1  pulse coincident with DONE

Behaviour:
- Reset is asynchronous. State=IDLE; all internal registers 0; MEM_RE/MEM_WE/BUSY/DONE/FLAG_WE=0; FLAG_OUT=8'h00; MEM_ADDR=0.
- All outputs are decoded from registered state and data only. Reset asserted mid-operation kills any strobe immediately, and no partial write completes afterwards.
- RMW set: INC, DEC, ASL, LSR, ROL, ROR. Every other OP value is a read-only op.
- States: IDLE, RD, CAP, EVAL, DWR, FWR, FIN.
- IDLE: if START=1, latch ADDR/OP/OPB/FLAG_IN and go to RD. START in any other state is ignored (not queued).
- RD: MEM_ADDR=addr_q, MEM_RE=1. Next state is CAP.
- CAP: MEM_RE=0. Latch MEM_RDATA into data_q. Next state is DWR for RMW ops, EVAL otherwise.
- EVAL: latch ALU_OUT into res_q and ALU_FLAG_OUT into flag_q. Next state is FIN.
- DWR: MEM_WE=1, MEM_WDATA=data_q (original value). Latch ALU_OUT into res_q and ALU_FLAG_OUT into flag_q. Next state is FWR.
- FWR: MEM_WE=1, MEM_WDATA=res_q. Next state is FIN.
- FIN: DONE=1, FLAG_WE=1, FLAG_OUT=flag_q. Next state is IDLE. FLAG_OUT holds its value until the next FIN.
- ALU drive is constant throughout an operation: ALU_A=data_q, ALU_B=opb_q, ALU_CTRL=op_q, ALU_FLAG=flag_in_q. Carry for ROL/ROR/ADC/SBC therefore comes from the value latched at START.
- MEM_ADDR=addr_q in RD, DWR and FWR; MEM_ADDR=0 otherwise. MEM_WDATA=0 when MEM_WE=0.
- Latency, counted from the cycle START is sampled:
  - RMW: DONE in the 5th following cycle; total 6 cycles START-to-IDLE.
  - Read-only: DONE in the 4th following cycle.
- MEM_RE and MEM_WE are never both high. There is exactly one read per op, and exactly two writes per RMW op (same address, dummy first).
- Back-to-back: START may be asserted in the FIN cycle, but it is ignored there. It is accepted in the following IDLE cycle, so the minimum spacing between accepted STARTs is latency+1.

Test Plan:
- RMW INC: ADDR=16'h0200, mem=8'h7F, FLAG_IN=8'h20 -> RE@0200. Writes 8'h7F then 8'h80 to 0200. FLAG_OUT=8'hA0 (N=1, Z=0). DONE 5 cycles after START.
- RMW ROL, carry-in: mem=8'h80, FLAG_IN=8'h01 -> writes 8'h80 then 8'h01. FLAG_OUT C=1, Z=0, N=0.
- Read-only CMP: mem=8'h10, OPB=8'h10 -> no MEM_WE at any cycle. FLAG_OUT Z=1, C=0. DONE 4 cycles after START.
- START held high continuously for 20 cycles with INC on mem=8'hFF -> each op completes with writes 8'hFF then 8'h00, Z=1. Ops are spaced exactly 6 cycles apart, with no START captured mid-op.
- Reset: assert RST_N=0 during DWR (MEM_WE high) -> MEM_WE drops with no clock edge. After release the block stays in IDLE, BUSY=0, FLAG_OUT=8'h00, and no FWR write ever occurs.
- OP/ADDR/OPB changed on the inputs mid-operation -> the bus address, write data and flags all reflect the values latched at START.
